lane_order_pipe: RTL and testbench

//   Parametrised lane-reordering register stage. Accepts a bus of LANES lanes,

---
 rtl/lane_order_pipe_if.sv | 26 ++
 rtl/lane_order_pipe.sv | 77 +++++++
 tb/tb_lane_order_pipe.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/lane_order_pipe_if.sv
// Handshake bundle for lane_order_pipe: input beat with its mode/rot, permuted output beat, transfer counter.
interface lane_order_pipe_if #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int ROT_W = 2
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic [1:0]             mode;
  logic [ROT_W-1:0]       rot;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_data;
  logic [15:0]            xfer_count;

  modport master (
    output in_valid, in_data, mode, rot, out_ready,
    input  in_ready, out_valid, out_data, xfer_count
  );

  modport slave (
    input  in_valid, in_data, mode, rot, out_ready,
    output in_ready, out_valid, out_data, xfer_count
  );
endinterface

// File: rtl/lane_order_pipe.sv
// Lane permutation (straight/reverse/rotl/pair-swap) applied on accept; 1-clk latency, 1 beat/clk.
// Main + skid register; in_ready comes straight from the skid flop, so no comb path from out_ready.
module lane_order_pipe #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int ROT_W = 2
) (
  input logic            clk,
  input logic            reset,
  lane_order_pipe_if.slave bus
);
  localparam int DW = LANES * WIDTH;

  logic [DW-1:0] perm_data;
  logic [DW-1:0] main_data;
  logic [DW-1:0] skid_data;
  logic          main_valid;
  logic          skid_valid;
  logic [15:0]   xfer_q;
  logic          accept;
  logic          drain;

  // Each input lane i is scattered to its destination lane.
  always_comb begin
    int dst;
    perm_data = '0;
    dst = 0;
    for (int i = 0; i < LANES; i++) begin
      case (bus.mode)
        2'b01:   dst = LANES - 1 - i;
        2'b10:   dst = (i + int'(bus.rot)) % LANES;
        2'b11:   dst = ((i ^ 1) < LANES) ? (i ^ 1) : i;
        default: dst = i;
      endcase
      perm_data[dst*WIDTH +: WIDTH] = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  assign accept = bus.in_valid && !skid_valid;
  assign drain  = main_valid && bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
      xfer_q     <= 16'd0;
    end else begin
      if (drain) begin
        xfer_q <= xfer_q + 16'd1;
        // A full skid blocks accept, so refilling from it never races a new beat.
        if (skid_valid) begin
          main_data  <= skid_data;
          skid_valid <= 1'b0;
        end else if (accept) begin
          main_data <= perm_data;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        if (!main_valid) begin
          main_data  <= perm_data;
          main_valid <= 1'b1;
        end else begin
          skid_data  <= perm_data;
          skid_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready   = !skid_valid;
  assign bus.out_valid  = main_valid;
  assign bus.out_data   = main_data;
  assign bus.xfer_count = xfer_q;
endmodule

// File: tb/tb_lane_order_pipe.sv
// Randomized + directed bench for lane_order_pipe against a queue-based reference model.
module tb_lane_order_pipe;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  lane_order_pipe_if #(.LANES(4), .WIDTH(8), .ROT_W(2)) bus ();

  lane_order_pipe #(.LANES(4), .WIDTH(8), .ROT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mq[$];
  logic [15:0] mcnt = 16'd0;

  // Reference: for each output lane, find which input lane feeds it.
  function automatic logic [31:0] model_perm(input logic [31:0] d, input logic [1:0] m, input logic [1:0] r);
    logic [7:0] lanes_in [4];
    logic [31:0] res;
    int src;
    for (int k = 0; k < 4; k++) lanes_in[k] = d[k*8 +: 8];
    res = '0;
    for (int j = 0; j < 4; j++) begin
      case (m)
        2'b00: src = j;
        2'b01: src = 3 - j;
        2'b10: src = (j - (int'(r) % 4) + 4) % 4;
        default: src = ((j ^ 1) < 4) ? (j ^ 1) : j;
      endcase
      res[j*8 +: 8] = lanes_in[src];
    end
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mq.delete();
      mcnt = 16'd0;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_xfer_count", {16'd0, bus.xfer_count}, 32'd0);
      chk("rst_out_data", bus.out_data, 32'd0);
    end else begin
      logic ev, er, dd, da;
      ev = (mq.size() > 0);
      er = (mq.size() < 2);
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, ev});
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, er});
      chk("xfer_count", {16'd0, bus.xfer_count}, {16'd0, mcnt});
      if (ev) chk("out_data", bus.out_data, mq[0]);
      dd = ev && bus.out_ready;
      da = er && bus.in_valid;
      if (dd) begin
        void'(mq.pop_front());
        mcnt = mcnt + 16'd1;
      end
      if (da) mq.push_back(model_perm(bus.in_data, bus.mode, bus.rot));
    end
  end

  task automatic drv(input logic v, input logic [31:0] d, input logic [1:0] m, input logic [1:0] r, input logic ordy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.mode      = m;
    bus.rot       = r;
    bus.out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drv(1'b0, 32'd0, 2'b00, 2'd0, 1'b0);
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  localparam logic [31:0] PAT = 32'h44332211;

  initial begin
    drv(1'b0, 32'd0, 2'b00, 2'd0, 1'b0);
    step();
    step();
    reset = 1'b1;

    // Model pinned to hand-computed permutations.
    chk("model_straight", model_perm(PAT, 2'b00, 2'd0), 32'h44332211);
    chk("model_reverse", model_perm(PAT, 2'b01, 2'd0), 32'h11223344);
    chk("model_rotl1", model_perm(PAT, 2'b10, 2'd1), 32'h33221144);
    chk("model_swap", model_perm(PAT, 2'b11, 2'd3), 32'h33441122);

    // Back-to-back A,B,C, each with its own mode.
    drv(1'b1, PAT, 2'b00, 2'd0, 1'b1);
    step();
    chk("b2b_A", bus.out_data, 32'h44332211);
    drv(1'b1, PAT, 2'b01, 2'd0, 1'b1);
    step();
    chk("b2b_B", bus.out_data, 32'h11223344);
    chk("b2b_B_valid", {31'd0, bus.out_valid}, 32'd1);
    drv(1'b1, PAT, 2'b10, 2'd1, 1'b1);
    step();
    chk("b2b_C", bus.out_data, 32'h33221144);
    chk("b2b_C_valid", {31'd0, bus.out_valid}, 32'd1);
    drv(1'b0, PAT, 2'b00, 2'd0, 1'b1);
    step();
    chk("b2b_count", {16'd0, bus.xfer_count}, 32'd3);
    chk("b2b_idle", {31'd0, bus.out_valid}, 32'd0);

    drv(1'b1, PAT, 2'b11, 2'd2, 1'b1);
    step();
    drv(1'b0, PAT, 2'b00, 2'd0, 1'b1);
    chk("swap_out", bus.out_data, 32'h33441122);
    step();

    // Backpressure: A,B fill main+skid, C waits.
    drv(1'b1, 32'hA0A1A2A3, 2'b01, 2'd0, 1'b0);
    step();
    drv(1'b1, 32'hB0B1B2B3, 2'b10, 2'd1, 1'b0);
    step();
    drv(1'b1, 32'hC0C1C2C3, 2'b11, 2'd0, 1'b0);
    step();
    step();
    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_hold_A", bus.out_data, 32'hA3A2A1A0);
    bus.out_ready = 1'b1;
    begin
      bit taken = 1'b0;
      for (int k = 0; k < 8 && !taken; k++) begin
        if (bus.in_ready) taken = 1'b1;
        step();
      end
      chk("bp_C_accepted", {31'd0, taken}, 32'd1);
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("bp_drained", {31'd0, bus.out_valid}, 32'd0);

    // Asynchronous reset while full.
    drv(1'b1, 32'h01020304, 2'b00, 2'd0, 1'b0);
    step();
    drv(1'b1, 32'h05060708, 2'b00, 2'd0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("arst_xfer", {16'd0, bus.xfer_count}, 32'd0);
    step();
    reset = 1'b1;
    drv(1'b1, PAT, 2'b01, 2'd0, 1'b1);
    step();
    drv(1'b0, PAT, 2'b00, 2'd0, 1'b1);
    chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("post_rst_data", bus.out_data, 32'h11223344);
    step();

    // Randomized traffic.
    for (int k = 0; k < 2000; k++) begin
      drv(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
      step();
    end
    drv(1'b0, 32'd0, 2'b00, 2'd0, 1'b1);
    for (int k = 0; k < 4; k++) step();

    // Counter wrap.
    do_reset();
    drv(1'b1, 32'h0, 2'b00, 2'd0, 1'b1);
    for (int k = 0; k < 65535; k++) begin
      bus.in_data = $urandom;
      step();
    end
    bus.in_valid = 1'b0;
    step();
    step();
    chk("wrap_ffff", {16'd0, bus.xfer_count}, 32'h0000FFFF);
    drv(1'b1, PAT, 2'b00, 2'd0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("wrap_zero", {16'd0, bus.xfer_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
